// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug blocks.
//   dump_state_e : frame state machine of the data-memory dump unit
//   DumpHdrByte  : default first byte of every dump frame
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StRd,
        StCap,
        StSend,
        StCsum,
        StDone
    } dump_state_e;

    localparam logic [7:0] DumpHdrByte = 8'hA5;

endpackage

// File: rtl/data_mem_dump.sv
// Debug readback of the CPU data memory. On dump_req_i it reads every byte
// through the memory's second read port and streams one frame:
// header, DEPTH data bytes, two's-complement checksum of the data bytes.
//
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   dump_req_i    : start a frame (sampled in idle only)
//   mem_ren_o     : data-memory read enable
//   mem_raddr_o   : data-memory read address
//   mem_rdata_i   : read data, valid one cycle after the mem_ren_o cycle
//   tx_data_o     : stream byte
//   tx_valid_o    : stream byte valid
//   tx_ready_i    : sink ready; a byte moves on valid && ready
//   tx_last_o     : marks the checksum byte
//   busy_o        : frame in progress
//   done_o        : one-cycle pulse after the checksum byte moves
module data_mem_dump
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter logic [7:0]  HDR_BYTE = DumpHdrByte,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dump_req_i,
    output logic          mem_ren_o,
    output logic [AW-1:0] mem_raddr_o,
    input  logic [7:0]    mem_rdata_i,
    output logic [7:0]    tx_data_o,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic          tx_last_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    dump_state_e   state_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    sum_q;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;
    logic          tx_last_q;
    logic          mem_ren_q;
    logic          busy_q;
    logic          done_q;

    // Every output is a register updated alongside the state, so nothing
    // downstream sees a combinational path from tx_ready_i or mem_rdata_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            sum_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            mem_ren_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (dump_req_i) begin
                        state_q    <= StHdr;
                        addr_q     <= '0;
                        sum_q      <= '0;
                        tx_data_q  <= HDR_BYTE;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                StHdr: begin
                    if (tx_ready_i) begin
                        state_q    <= StRd;
                        tx_valid_q <= 1'b0;
                        mem_ren_q  <= 1'b1;
                    end
                end
                StRd: begin
                    state_q   <= StCap;
                    mem_ren_q <= 1'b0;
                end
                StCap: begin
                    state_q    <= StSend;
                    tx_data_q  <= mem_rdata_i;
                    sum_q      <= sum_q + mem_rdata_i;
                    tx_valid_q <= 1'b1;
                end
                StSend: begin
                    if (tx_ready_i) begin
                        if (addr_q == LastAddr) begin
                            // Valid stays high: checksum follows directly.
                            state_q   <= StCsum;
                            tx_data_q <= ~sum_q + 8'd1;
                            tx_last_q <= 1'b1;
                        end else begin
                            state_q    <= StRd;
                            addr_q     <= addr_q + 1'b1;
                            tx_valid_q <= 1'b0;
                            mem_ren_q  <= 1'b1;
                        end
                    end
                end
                StCsum: begin
                    if (tx_ready_i) begin
                        state_q    <= StDone;
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                StDone: begin
                    // dump_req_i is deliberately not looked at here.
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_ren_o   = mem_ren_q;
    assign mem_raddr_o = addr_q;
    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_last_o   = tx_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: doc/data_mem_dump.md
# data_mem_dump

Debug readback unit for the accumulator CPU. On request it walks the CPU's 16×8 data memory through a read port and streams the contents out as one byte frame: header, 16 data bytes, checksum. It is the read side of the flat `init_data` load path. Benches and the board debug link use it to check post-run memory, for example the result left in mem_0, without probing internals. It sits beside the CPU's data memory, on the memory's second read port.

## Interface
Parameters:
- `DEPTH`, default 16: number of data-memory bytes dumped, addresses 0..DEPTH-1. `DEPTH` must be a power of 2, at most 256.
- `HDR_BYTE`, default 8'hA5: first byte of every frame.

Ports:
- `clk`, input, 1: single clock; all logic rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `dump_req`, input, 1: start a frame. Sampled only in IDLE.
- `mem_ren`, output, 1: data-memory read enable.
- `mem_raddr`, output, $clog2(DEPTH): data-memory read address.
- `mem_rdata`, input, 8: read data, valid exactly 1 cycle after the `mem_ren` cycle.
- `tx_data`, output, 8: stream byte.
- `tx_valid`, output, 1: `tx_data` is valid.
- `tx_ready`, input, 1: sink accepts the byte. A transfer happens on any edge where `tx_valid && tx_ready`.
- `tx_last`, output, 1: high with the checksum byte only.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse after the checksum transfer.

## Operation
- State machine:
  - IDLE → HDR on `dump_req`.
  - HDR → RD on transfer.
  - RD → CAP unconditionally.
  - CAP → SEND unconditionally.
  - SEND → RD on transfer if `addr != DEPTH-1`, else → CSUM on transfer.
  - CSUM → DONE on transfer.
  - DONE → IDLE unconditionally.
- HDR: `tx_data=HDR_BYTE`, `tx_valid=1`. The address counter and checksum accumulator are cleared on entry.
- RD: `mem_ren=1` for exactly one cycle, with `mem_raddr` = address counter.
- CAP:
  - `mem_rdata` is registered into the `tx_data` register.
  - `sum <= sum + mem_rdata`, mod 256.
  - `tx_valid` is still 0 in this state.
- SEND: `tx_valid=1`. On transfer, the address counter increments, except on the last byte.
- CSUM: `tx_data = (~sum + 1) & 8'hFF`, the two's complement, so that (Σ data + checksum) mod 256 = 0. `tx_last=1`.
- DONE: `done=1` for one cycle; `busy` is still 1.
- Header is excluded from the checksum.
- Backpressure: while `tx_valid && !tx_ready`, `tx_data`, `tx_valid` and `tx_last` hold stable. `tx_valid` never drops without a transfer.
- `dump_req` while `busy` is ignored; it is neither queued nor restarting.
- `dump_req` in the DONE cycle is ignored. A new frame needs `dump_req` in IDLE.
- `mem_ren` is 0 in every state except RD.
- Reset, at any time including mid-frame:
  - state returns to IDLE; the frame is abandoned, with no truncation marker.
  - `mem_ren=0`, `mem_raddr=0`, `tx_data=0`, `tx_valid=0`, `tx_last=0`, `busy=0`, `done=0`.
  - sum and address counter are cleared.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from `tx_ready` or `mem_rdata` to any output.
- Start: `dump_req` sampled high at edge e gives `tx_valid` (header) and `busy` high from e+1.
- Per data byte with `tx_ready` tied high: transfer at edge k, `mem_ren` in cycle k+1, capture at edge k+2, `tx_valid` from k+3. That is 3 cycles per byte.
- Full frame with `tx_ready=1` (DEPTH=16):
  - header: 1 cycle.
  - data: 16×3 = 48 cycles.
  - checksum: 1 cycle.
  - DONE: 1 cycle.
  - total 51 cycles, from first `tx_valid` to `busy` low.
- Address wrap: the counter never wraps within a frame. The end-of-data condition is `addr == DEPTH-1` at the SEND transfer.

## Structure
- Shared package `cpu_dbg_pkg`: state enum (IDLE, HDR, RD, CAP, SEND, CSUM, DONE) and the default header constant 8'hA5. The same package will hold constants for future debug blocks.
- Single module, no sub-module.

## Test plan
- mem[0]=8'h0A, rest 0, `tx_ready=1`, `dump_req` pulse → 18 bytes: A5, 0A, 15×00, F6; `tx_last` only on F6; `done` 1 cycle later; 51 cycles from first `tx_valid` to `busy` low.
- All 16 bytes = 8'hFF → data 16×FF, checksum 8'h10.
- `tx_ready` toggled with a random pattern during a full frame → byte sequence identical to the previous case; `tx_data` stable whenever valid and not ready.
- `dump_req` held high for a whole frame → exactly one frame, then a second header starts; `mem_raddr` sequence 0..15 exactly once per frame.
- `rst_n` low during SEND of byte 7 → all outputs 0 asynchronously; after release, `dump_req` → full fresh frame starting with A5 and address 0.
- `tx_ready=0` throughout → header held with `tx_valid=1`, `mem_ren` never asserted, `busy=1` indefinitely.
